// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO.
// Define MULDIV_EARLY_OUT_EN to let multiply exit once the multiplier is exhausted.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvsr;
  logic [WIDTH-1:0]   dvnd;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               dbz;

  logic               sgn;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     sh;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   qout;
  logic [WIDTH-1:0]   rout;
  logic               mul_last;

  // Operand magnitudes, datapath step values and final sign fix-up.
  always_comb begin
    sgn   = ~funct[0];
    a_neg = sgn & a[WIDTH-1];
    b_neg = sgn & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} +
            (mplier[0] ? {1'b0, mcand} : '0);
    sh    = {rem, quo[WIDTH-1]};
    diff  = sh - {1'b0, dvsr};
    prod  = acc;
`ifdef MULDIV_EARLY_OUT_EN
    prod  = acc >> (CW'(WIDTH) - count);
    mul_last = (count == CW'(WIDTH - 1)) ||
               (mplier[WIDTH-1:1] == '0);
`else
    mul_last = (count == CW'(WIDTH - 1));
`endif
    prod  = neg_q ? -prod : prod;
    qout  = neg_q ? -quo : quo;
    rout  = neg_r ? -rem : rem;
  end

  // Control FSM with registered HI/LO, busy, done and flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      rem         <= '0;
      quo         <= '0;
      dvsr        <= '0;
      dvnd        <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            case (funct)
              6'h11: hi <= a;
              6'h13: lo <= a;
              6'h18, 6'h19, 6'h1A, 6'h1B: begin
                is_div      <= funct[1];
                neg_q       <= a_neg ^ b_neg;
                neg_r       <= a_neg;
                dbz         <= funct[1] & (b == '0);
                div_by_zero <= 1'b0;
                count       <= '0;
                acc         <= '0;
                mcand       <= a_mag;
                mplier      <= b_mag;
                rem         <= '0;
                quo         <= a_mag;
                dvsr        <= b_mag;
                dvnd        <= a;
                busy        <= 1'b1;
                state       <= funct[1] ? DIV : MUL;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          acc    <= {sum, acc[WIDTH-1:1]};
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (mul_last) state <= FIX;
        end
        DIV: begin
          if (!diff[WIDTH]) begin
            rem <= diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (is_div && dbz) begin
            hi          <= dvnd;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else if (is_div) begin
            hi <= rout;
            lo <= qout;
          end else begin
            {hi, lo} <= prod;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
